// File: rtl/arith_seq_unit.sv
// arith_seq_unit: sign-magnitude restoring divider with an optional shift-add multiplier, one bit per clock.
// Defining ARITH_MUL_EN compiles in the multiply datapath; without it op is ignored and every operation divides.
module arith_seq_unit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] b_mag,
  input  logic         sign_a,
  input  logic         sign_b,
  output logic         ready,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_hi,
  output logic         sign_q,
  output logic         sign_r,
  output logic         done,
  output logic         error_div0
);

  // Handshake: start is taken on a rising edge only while ready=1; ready is low from the
  // cycle after acceptance until the cycle after the one-cycle done pulse. Ignored starts are not queued.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  b_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic          sa_q;
  logic          sb_q;
  logic          accept;
  logic          div0;
  logic          op_eff;
  logic [W:0]    part_rem;
  logic [W:0]    trial;
  logic [W-1:0]  quo_nxt;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  fin_lo;
  logic [W-1:0]  fin_hi;
  logic          fin_sq;
  logic          fin_sr;

`ifdef ARITH_MUL_EN
  logic [W-1:0]   a_q;
  logic           op_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_nxt;
  logic [W:0]     sum;

  assign op_eff = op;
`else
  logic unused_op;

  assign unused_op = op;
  assign op_eff    = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  assign div0   = !op_eff && (b_mag == '0);
  assign ready  = (state == IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = div0 ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The remainder always stays below the divisor, so only the shifted trial value needs W+1 bits.
  always_comb begin
    part_rem = {rem_q, quo_q[W-1]};
    trial    = part_rem - {1'b0, b_q};
    rem_nxt  = trial[W] ? part_rem[W-1:0] : trial[W-1:0];
    quo_nxt  = {quo_q[W-2:0], ~trial[W]};
  end

`ifdef ARITH_MUL_EN
  // Multiplier occupies the low half of the accumulator and is consumed LSB first.
  always_comb begin
    sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_nxt = {sum, acc_q[W-1:1]};
  end
`endif

  always_comb begin
    fin_lo = quo_nxt;
    fin_hi = rem_nxt;
    fin_sq = (sa_q ^ sb_q) & (|quo_nxt);
    fin_sr = sa_q & (|rem_nxt);
`ifdef ARITH_MUL_EN
    if (op_q) begin
      fin_lo = acc_nxt[W-1:0];
      fin_hi = acc_nxt[2*W-1:W];
      fin_sq = (sa_q ^ sb_q) & (|acc_nxt);
      fin_sr = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      res_lo     <= '0;
      res_hi     <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      error_div0 <= 1'b0;
    end else if (accept) begin
      cnt        <= CW'(W - 1);
      b_q        <= b_mag;
      quo_q      <= a_mag;
      rem_q      <= '0;
      sa_q       <= sign_a;
      sb_q       <= sign_b;
      error_div0 <= div0;
      if (div0) begin
        res_lo <= '0;
        res_hi <= '0;
        sign_q <= 1'b0;
        sign_r <= 1'b0;
      end
    end else if (state == CALC) begin
      cnt   <= cnt - CW'(1);
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      // Results are published on the final iteration edge, coinciding with entry to DONE.
      if (cnt == '0) begin
        res_lo <= fin_lo;
        res_hi <= fin_hi;
        sign_q <= fin_sq;
        sign_r <= fin_sr;
      end
    end
  end

`ifdef ARITH_MUL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      op_q  <= 1'b0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= a_mag;
      op_q  <= op;
      acc_q <= {{W{1'b0}}, b_mag};
    end else if (state == CALC) begin
      acc_q <= acc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_arith_seq_unit.sv
// Bench for arith_seq_unit (W=16): directed cases, randomized operations against an arithmetic
// reference model, handshake-ignore and mid-operation reset scenarios.
module tb_arith_seq_unit;
  localparam int W  = 16;
  localparam int RW = 2 * W + 3;
`ifdef ARITH_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         sq;
    logic         sr;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_mag = '0;
  logic [W-1:0] b_mag = '0;
  logic         sign_a = 1'b0;
  logic         sign_b = 1'b0;
  logic         ready;
  logic [W-1:0] res_lo;
  logic [W-1:0] res_hi;
  logic         sign_q;
  logic         sign_r;
  logic         done;
  logic         error_div0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  arith_seq_unit #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .sign_a     (sign_a),
    .sign_b     (sign_b),
    .ready      (ready),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .sign_q     (sign_q),
    .sign_r     (sign_r),
    .done       (done),
    .error_div0 (error_div0)
  );

  // reference model: plain arithmetic on magnitudes plus the sign rules
  function automatic res_t model(input logic m_op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sa, input logic sb);
    res_t r;
    logic [63:0] p;
    r = '0;
    if (MUL_EN && m_op) begin
      p    = 64'(a) * 64'(b);
      r.lo = p[W-1:0];
      r.hi = p[2*W-1:W];
      r.sq = (sa ^ sb) && (p != 0);
    end else if (b == 0) begin
      r.err = 1'b1;
    end else begin
      r.lo = a / b;
      r.hi = a % b;
      r.sq = (sa ^ sb) && (r.lo != 0);
      r.sr = sa && (r.hi != 0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one operation, latency and result checked through the expected queue
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb);
    res_t e;
    logic [RW-1:0] want;
    int cyc;
    e = model(o, a, b, sa, sb);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a_mag = a; b_mag = b; sign_a = sa; sign_b = sb;
    @(negedge clk);
    start  = 1'b0;
    op     = 1'($urandom);
    a_mag  = W'($urandom);
    b_mag  = W'($urandom);
    sign_a = 1'($urandom);
    sign_b = 1'($urandom);
    check({tag, "_ready_low"}, ready, 1'b0);
    cyc = 1;
    while (done !== 1'b1 && cyc < W + 10) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, e.err ? 1 : W + 1);
    want = exp_q.pop_front();
    check({tag, "_result"}, {res_lo, res_hi, sign_q, sign_r, error_div0}, want);
    @(negedge clk);
    check({tag, "_done_pulse"}, {ready, done}, 2'b10);
    check({tag, "_hold"}, {res_lo, res_hi, sign_q, sign_r, error_div0}, want);
  endtask

  initial begin
    res_t e;
    int done_cnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {ready, done, res_lo, res_hi, sign_q, sign_r, error_div0}, {2'b10, {RW{1'b0}}});
    rst = 1'b1;

    // directed cases
    run_op("div_100_7", 1'b0, 16'd100, 16'd7, 1'b0, 1'b0);
    check("div_100_7_lo", res_lo, 16'd14);
    run_op("div_m100_7", 1'b0, 16'd100, 16'd7, 1'b1, 1'b0);
    run_op("div_m100_m7", 1'b0, 16'd100, 16'd7, 1'b1, 1'b1);
    run_op("div_0_m3", 1'b0, 16'd0, 16'd3, 1'b0, 1'b1);
    run_op("div_5_0", 1'b0, 16'd5, 16'd0, 1'b0, 1'b0);
    run_op("div_9_3", 1'b0, 16'd9, 16'd3, 1'b0, 1'b0);
    run_op("op1_300_m250", 1'b1, 16'd300, 16'd250, 1'b0, 1'b1);
    run_op("div_max_max", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    run_op("div_max_1", 1'b0, 16'hFFFF, 16'd1, 1'b0, 1'b1);
    run_op("div_m1_max", 1'b0, 16'd1, 16'hFFFF, 1'b1, 1'b0);
    run_op("op1_max_max", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op($sformatf("rand%0d", i), 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
    end

    // starts while busy are ignored and not queued
    e = model(1'b0, 16'd1234, 16'd56, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_mag = 16'd1234; b_mag = 16'd56; sign_a = 1'b1; sign_b = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start  = (c == 5 || c == 12);
      a_mag  = W'($urandom);
      b_mag  = W'($urandom_range(1, 200));
      sign_a = 1'($urandom);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          check("busy_start_latency", c, W + 1);
          check("busy_start_result", {res_lo, res_hi, sign_q, sign_r, error_div0}, e);
        end
      end
    end
    start = 1'b0;
    check("busy_start_done_count", done_cnt, 1);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; a_mag = 16'd500; b_mag = 16'd3; sign_a = 1'b0; sign_b = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_reset_outputs", {ready, done, res_lo, res_hi, sign_q, sign_r, error_div0},
          {2'b10, {RW{1'b0}}});
    done_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 2) rst = 1'b1;
      if (done === 1'b1) done_cnt++;
    end
    check("midop_reset_no_done", done_cnt, 0);
    run_op("after_reset_div", 1'b0, 16'd500, 16'd3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
